// File: rtl/io_in_fifo.sv
// Input-port FIFO peripheral: buffers a valid/ready sample stream for INN reads
// at a data port (pop) and a status port, and pulses itr on a fill-level crossing.
module io_in_fifo #(
    parameter int NUBITS = 16,
    parameter int NBIOIN = 2,
    parameter int DEPTH  = 16,
    parameter int DADDR  = 0,
    parameter int SADDR  = 1,
    parameter int ITRLVL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              req_in,
    input  logic [NBIOIN-1:0] addr_in,
    output logic [NUBITS-1:0] io_in,
    output logic              itr,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0]     ITR_LVL  = CW'(ITRLVL);
    localparam logic [NBIOIN-1:0] D_ADDR   = NBIOIN'(DADDR);
    localparam logic [NBIOIN-1:0] S_ADDR   = NBIOIN'(SADDR);

    logic [NUBITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              itr_q, itr_d;

    logic push, pop, data_rd, stat_rd, udf_set, ovf_set;
    logic [NUBITS-1:0] status;

    // Valid/ready: a sample transfers on any posedge where s_valid and s_ready are both
    // high; s_ready depends on the registered count only, never on the read side.
    assign s_ready = (count_q != FULL_LVL);
    assign push    = s_valid & s_ready;
    assign ovf_set = s_valid & ~s_ready;
    assign data_rd = req_in & (addr_in == D_ADDR);
    assign stat_rd = req_in & (addr_in == S_ADDR);
    assign pop     = data_rd & (count_q != '0);
    assign udf_set = data_rd & (count_q == '0);

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // A flag raised in the same cycle as a status read survives the clear.
        ovf_d = ovf_set | (ovf_q & ~stat_rd);
        udf_d = udf_set | (udf_q & ~stat_rd);
        itr_d = (ITRLVL != 0) && (count_d >= ITR_LVL) && (count_q < ITR_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            itr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            itr_q   <= itr_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= s_data;
        end
    end

    always_comb begin
        status         = '0;
        status[CW-1:0] = count_q;
        status[CW]     = ovf_q;
        status[CW+1]   = udf_q;
    end

    always_comb begin
        io_in = '0;
        if (addr_in == D_ADDR) begin
            if (count_q != '0) begin
                io_in = mem_q[rptr_q];
            end
        end else if (addr_in == S_ADDR) begin
            io_in = status;
        end
    end

    assign itr = itr_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_io_in_fifo.sv
// Directed bench for io_in_fifo: one task per scenario, inline comparisons,
// single summary line at the end.
module tb_io_in_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        req_in;
    logic [1:0]  addr_in;
    logic [15:0] io_in;
    logic        itr;
    logic        ovf;

    int n_cmp;
    int n_err;

    io_in_fifo #(
        .NUBITS(16), .NBIOIN(2), .DEPTH(16), .DADDR(0), .SADDR(1), .ITRLVL(8)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .req_in(req_in), .addr_in(addr_in), .io_in(io_in), .itr(itr), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are checked before the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        s_valid = 1'b0;
        req_in  = 1'b0;
        addr_in = 2'd0;
    endtask

    task automatic push_n(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 16'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        n_cmp++;
        if (itr !== 1'b0) begin n_err++; $display("FAIL reset_itr got %b exp 0", itr); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        req_in = 1'b1; addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL reset_status got %h exp 0000", io_in); end
        tick();
        idle();
    endtask

    task automatic test_basic;
        s_valid = 1'b1; s_data = 16'h0011; tick();
        s_data = 16'h0022; tick();
        s_data = 16'h0033; tick();
        s_valid = 1'b0;
        req_in = 1'b1; addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0003) begin n_err++; $display("FAIL basic_status got %h exp 0003", io_in); end
        tick();
        addr_in = 2'd0;
        #1;
        n_cmp++;
        if (io_in !== 16'h0011) begin n_err++; $display("FAIL basic_rd0 got %h exp 0011", io_in); end
        tick();
        n_cmp++;
        if (io_in !== 16'h0022) begin n_err++; $display("FAIL basic_rd1 got %h exp 0022", io_in); end
        tick();
        n_cmp++;
        if (io_in !== 16'h0033) begin n_err++; $display("FAIL basic_rd2 got %h exp 0033", io_in); end
        tick();
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL basic_rd_empty got %h exp 0000", io_in); end
        tick();
        addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0040) begin n_err++; $display("FAIL basic_udf_status got %h exp 0040", io_in); end
        tick();
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL basic_udf_cleared got %h exp 0000", io_in); end
        tick();
        idle();
    endtask

    task automatic test_overflow;
        logic exp_ready;
        logic exp_ovf;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            // Source holds the unaccepted sample, as valid/ready requires.
            s_data  = 16'h0100 + 16'((i < 16) ? i : 16);
            exp_ready = (i < 16);
            exp_ovf   = (i >= 17);
            #1;
            n_cmp++;
            if (s_ready !== exp_ready) begin n_err++; $display("FAIL ovf_s_ready cyc %0d got %b exp %b", i, s_ready, exp_ready); end
            n_cmp++;
            if (ovf !== exp_ovf) begin n_err++; $display("FAIL ovf_flag cyc %0d got %b exp %b", i, ovf, exp_ovf); end
            tick();
        end
        s_valid = 1'b0;
        req_in = 1'b1; addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0030) begin n_err++; $display("FAIL ovf_status got %h exp 0030", io_in); end
        tick();
        n_cmp++;
        if (io_in !== 16'h0010) begin n_err++; $display("FAIL ovf_status_cleared got %h exp 0010", io_in); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_port_cleared got %b exp 0", ovf); end
        addr_in = 2'd0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_cmp++;
            if (io_in !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL ovf_drain %0d got %h exp %h", i, io_in, 16'h0100 + 16'(i)); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_itr;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 16'h0200 + 16'(i);
            #1;
            n_cmp++;
            if (itr !== 1'b0) begin n_err++; $display("FAIL itr_early cyc %0d got %b exp 0", i, itr); end
            tick();
        end
        s_data = 16'h0208;
        n_cmp++;
        if (itr !== 1'b1) begin n_err++; $display("FAIL itr_pulse1 got %b exp 1", itr); end
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if (itr !== 1'b0) begin n_err++; $display("FAIL itr_ninth got %b exp 0", itr); end
        req_in = 1'b1; addr_in = 2'd0;
        tick();
        tick();
        req_in = 1'b0;
        n_cmp++;
        if (itr !== 1'b0) begin n_err++; $display("FAIL itr_on_drop got %b exp 0", itr); end
        s_valid = 1'b1; s_data = 16'h0209;
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if (itr !== 1'b1) begin n_err++; $display("FAIL itr_pulse2 got %b exp 1", itr); end
        tick();
        n_cmp++;
        if (itr !== 1'b0) begin n_err++; $display("FAIL itr_pulse2_width got %b exp 0", itr); end
        req_in = 1'b1; addr_in = 2'd0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (io_in !== 16'h0202 + 16'(i)) begin n_err++; $display("FAIL itr_drain %0d got %h exp %h", i, io_in, 16'h0202 + 16'(i)); end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back;
        push_n(5, 16'h0300);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 16'h0305 + 16'(i);
            req_in = 1'b1; addr_in = 2'd0;
            #1;
            n_cmp++;
            if (io_in !== 16'h0300 + 16'(i)) begin n_err++; $display("FAIL b2b_rd %0d got %h exp %h", i, io_in, 16'h0300 + 16'(i)); end
            tick();
        end
        s_valid = 1'b0;
        addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0005) begin n_err++; $display("FAIL b2b_count got %h exp 0005", io_in); end
        tick();
        addr_in = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (io_in !== 16'h030A + 16'(i)) begin n_err++; $display("FAIL b2b_drain %0d got %h exp %h", i, io_in, 16'h030A + 16'(i)); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid;
        push_n(7, 16'h0400);
        // Reset lands on the edge that would take count 7->8 and fire itr.
        s_valid = 1'b1; s_data = 16'h0407; rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        n_cmp++;
        if (itr !== 1'b0) begin n_err++; $display("FAIL rstmid_itr got %b exp 0", itr); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf got %b exp 0", ovf); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_s_ready got %b exp 1", s_ready); end
        req_in = 1'b1; addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL rstmid_status got %h exp 0000", io_in); end
        tick();
        addr_in = 2'd0;
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL rstmid_data got %h exp 0000", io_in); end
        tick();
        addr_in = 2'd1;
        tick();
        idle();
    endtask

    task automatic test_other_addr;
        push_n(4, 16'h0500);
        req_in = 1'b1; addr_in = 2'd2;
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL addr2 got %h exp 0000", io_in); end
        tick();
        addr_in = 2'd3;
        #1;
        n_cmp++;
        if (io_in !== 16'h0000) begin n_err++; $display("FAIL addr3 got %h exp 0000", io_in); end
        tick();
        addr_in = 2'd1;
        #1;
        n_cmp++;
        if (io_in !== 16'h0004) begin n_err++; $display("FAIL other_count got %h exp 0004", io_in); end
        tick();
        addr_in = 2'd0;
        #1;
        n_cmp++;
        if (io_in !== 16'h0500) begin n_err++; $display("FAIL other_head got %h exp 0500", io_in); end
        idle();
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        s_data  = 16'h0000;
        s_valid = 1'b0;
        req_in  = 1'b0;
        addr_in = 2'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_itr();
        test_back_to_back();
        test_reset_mid();
        test_other_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
